generic_sw_regs: RTL and testbench



---
 rtl/generic_sw_regs.sv | 141 ++++++++++++++
 tb/tb_generic_sw_regs.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/generic_sw_regs.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : generic_sw_regs
// Purpose  : Register block on the CPCI bus. It holds software RW registers and
//            read-only status words, and returns a delayed one-shot ack.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`ifndef CPCI_NF2_DATA_WIDTH
`define CPCI_NF2_DATA_WIDTH 32
`endif

module generic_sw_regs #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int NUM_RW_REGS    = 4,
    parameter int NUM_RO_REGS    = 4,
    parameter int ACK_DELAY      = 0,
    parameter logic [`CPCI_NF2_DATA_WIDTH-1:0] RW_RESET_VAL    = '0,
    parameter logic [`CPCI_NF2_DATA_WIDTH-1:0] DEFAULT_RD_DATA = 32'hdead_beef
) (
    input  logic                                            clk,
    input  logic                                            reset,
    input  logic                                            reg_req,
    output logic                                            reg_ack,
    input  logic                                            reg_rd_wr_L,
    input  logic [REG_ADDR_WIDTH-1:0]                       reg_addr,
    output logic [`CPCI_NF2_DATA_WIDTH-1:0]                 reg_rd_data,
    input  logic [`CPCI_NF2_DATA_WIDTH-1:0]                 reg_wr_data,
    output logic [NUM_RW_REGS*`CPCI_NF2_DATA_WIDTH-1:0]     rw_regs,
    // Kept at least one word wide so that NUM_RO_REGS == 0 still elaborates.
    input  logic [((NUM_RO_REGS > 0) ? NUM_RO_REGS : 1)*`CPCI_NF2_DATA_WIDTH-1:0] ro_regs
);

    localparam int c_DW = `CPCI_NF2_DATA_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                    r_state;
    logic [3:0]                r_cnt;
    logic                      r_req_d1;
    logic                      r_ack;
    logic [c_DW-1:0]           r_rd_data;
    logic [c_DW-1:0]           r_rw [NUM_RW_REGS];
    logic [REG_ADDR_WIDTH-1:0] r_cap_addr;
    logic                      r_cap_rd;
    logic [c_DW-1:0]           r_cap_wdata;

    logic                      w_new_req;
    logic                      w_enter_ack;
    logic [REG_ADDR_WIDTH-1:0] w_addr;
    logic [31:0]               w_addr_ext;
    logic                      w_rd;
    logic [c_DW-1:0]           w_wdata;
    logic [c_DW-1:0]           w_rd_val;

    assign w_new_req   = reg_req && !r_req_d1;
    assign w_enter_ack = ((r_state == S_IDLE) && w_new_req && (ACK_DELAY == 0)) ||
                         ((r_state == S_WAIT) && (r_cnt == 4'd0));

    // With zero delay the ack edge is also the capture edge, so use the live bus.
    assign w_addr     = (r_state == S_IDLE) ? reg_addr    : r_cap_addr;
    assign w_rd       = (r_state == S_IDLE) ? reg_rd_wr_L : r_cap_rd;
    assign w_wdata    = (r_state == S_IDLE) ? reg_wr_data : r_cap_wdata;
    assign w_addr_ext = 32'(w_addr);

    always_comb begin
        w_rd_val = DEFAULT_RD_DATA;
        for (int i = 0; i < NUM_RW_REGS; i++) begin
            if (w_addr_ext == 32'(i)) w_rd_val = r_rw[i];
        end
        for (int j = 0; j < NUM_RO_REGS; j++) begin
            if (w_addr_ext == 32'(NUM_RW_REGS + j)) w_rd_val = ro_regs[j*c_DW +: c_DW];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_req_d1    <= 1'b0;
            r_ack       <= 1'b0;
            r_rd_data   <= '0;
            r_cap_addr  <= '0;
            r_cap_rd    <= 1'b0;
            r_cap_wdata <= '0;
            for (int i = 0; i < NUM_RW_REGS; i++) r_rw[i] <= RW_RESET_VAL;
        end else begin
            r_req_d1 <= reg_req;
            r_ack    <= w_enter_ack;

            if (w_enter_ack) begin
                if (w_rd) begin
                    r_rd_data <= w_rd_val;
                end else begin
                    for (int i = 0; i < NUM_RW_REGS; i++) begin
                        if (w_addr_ext == 32'(i)) r_rw[i] <= w_wdata;
                    end
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (w_new_req) begin
                        r_cap_addr  <= reg_addr;
                        r_cap_rd    <= reg_rd_wr_L;
                        r_cap_wdata <= reg_wr_data;
                        if (ACK_DELAY == 0) begin
                            r_state <= S_ACK;
                        end else begin
                            r_cnt   <= 4'(ACK_DELAY - 1);
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) r_state <= S_ACK;
                    else               r_cnt   <= r_cnt - 4'd1;
                end
                S_ACK:  r_state <= S_DONE;
                S_DONE: if (!reg_req) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign reg_ack     = r_ack;
    assign reg_rd_data = r_rd_data;

    generate
        for (genvar g = 0; g < NUM_RW_REGS; g++) begin : g_rw_out
            assign rw_regs[g*c_DW +: c_DW] = r_rw[g];
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_generic_sw_regs.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_generic_sw_regs
// Purpose  : Self-checking bench with three instances of generic_sw_regs,
//            using ACK_DELAY values 0, 3 and 2.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`ifndef CPCI_NF2_DATA_WIDTH
`define CPCI_NF2_DATA_WIDTH 32
`endif

module tb_generic_sw_regs;

    localparam int DW  = 32;
    localparam int NRW = 4;
    localparam int NRO = 4;
    localparam int AW  = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]         rst, req, rdwr, ack;
    logic [AW-1:0]      addr  [3];
    logic [DW-1:0]      wdata [3];
    logic [DW-1:0]      rdd   [3];
    logic [NRW*DW-1:0]  rw    [3];
    logic [NRO*DW-1:0]  ro;

    generate
        for (genvar g = 0; g < 3; g++) begin : g_dut
            generic_sw_regs #(
                .REG_ADDR_WIDTH (AW),
                .NUM_RW_REGS    (NRW),
                .NUM_RO_REGS    (NRO),
                .ACK_DELAY      ((g == 0) ? 0 : ((g == 1) ? 3 : 2)),
                .RW_RESET_VAL   (32'h0),
                .DEFAULT_RD_DATA(32'hdead_beef)
            ) u_dut (
                .clk        (clk),
                .reset      (rst[g]),
                .reg_req    (req[g]),
                .reg_ack    (ack[g]),
                .reg_rd_wr_L(rdwr[g]),
                .reg_addr   (addr[g]),
                .reg_rd_data(rdd[g]),
                .reg_wr_data(wdata[g]),
                .rw_regs    (rw[g]),
                .ro_regs    (ro)
            );
        end
    endgenerate

    typedef struct {
        logic          rd;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        logic [DW-1:0] exp_rd;
    } vec_t;

    typedef struct {
        logic [DW-1:0]     rd;
        logic [NRW*DW-1:0] rwv;
        int                lat;
    } exp_t;

    exp_t        sbq[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] m0 [NRW];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one transaction and queue what it should produce. The expected
    // entry is popped when the ack is seen. Then release the request and let
    // the FSM return to IDLE.
    task automatic do_txn(input int d, input logic rd, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd, input logic [DW-1:0] exp_rd,
                          input logic [NRW*DW-1:0] exp_rw, input int exp_lat,
                          input string name);
        exp_t e;
        int   k;
        bit   got;
        e.rd = exp_rd; e.rwv = exp_rw; e.lat = exp_lat;
        sbq.push_back(e);
        rdwr[d] = rd; addr[d] = a; wdata[d] = wd; req[d] = 1'b1;
        k = 0; got = 0;
        while (!got && k < 20) begin
            tick();
            k++;
            if (ack[d]) got = 1;
        end
        e = sbq.pop_front();
        if (!got) begin
            check({name, " ack timeout"}, 128'd0, 128'd1);
        end else begin
            check({name, " latency"}, 128'(k), 128'(e.lat));
            check({name, " rd_data"}, 128'(rdd[d]), 128'(e.rd));
            check({name, " rw_regs"}, rw[d], e.rwv);
        end
        req[d] = 1'b0;
        tick();
        check({name, " ack one cycle"}, 128'(ack[d]), 128'd0);
        tick();
    endtask

    vec_t tbl [16];

    initial begin : main
        int cnt;
        int at;
        int k;
        bit got;

        tbl[0]  = '{1'b1, 5'd0,  32'h0,         32'h0};
        tbl[1]  = '{1'b1, 5'd1,  32'h0,         32'h0};
        tbl[2]  = '{1'b1, 5'd2,  32'h0,         32'h0};
        tbl[3]  = '{1'b1, 5'd3,  32'h0,         32'h0};
        tbl[4]  = '{1'b0, 5'd2,  32'h1234_5678, 32'h0};
        tbl[5]  = '{1'b1, 5'd2,  32'h0,         32'h1234_5678};
        tbl[6]  = '{1'b1, 5'd5,  32'h0,         32'hcafe_f00d};
        tbl[7]  = '{1'b0, 5'd5,  32'hffff_ffff, 32'hcafe_f00d};
        tbl[8]  = '{1'b1, 5'd31, 32'h0,         32'hdead_beef};
        tbl[9]  = '{1'b0, 5'd0,  32'ha5a5_0001, 32'hdead_beef};
        tbl[10] = '{1'b1, 5'd0,  32'h0,         32'ha5a5_0001};
        tbl[11] = '{1'b1, 5'd4,  32'h0,         32'h0bad_0000};
        tbl[12] = '{1'b0, 5'd31, 32'h7777_7777, 32'h0bad_0000};
        tbl[13] = '{1'b1, 5'd2,  32'h0,         32'h1234_5678};
        tbl[14] = '{1'b1, 5'd7,  32'h0,         32'h3333_4444};
        tbl[15] = '{1'b1, 5'd8,  32'h0,         32'hdead_beef};

        ro   = {32'h3333_4444, 32'h1111_2222, 32'hcafe_f00d, 32'h0bad_0000};
        rst  = 3'b111;
        req  = 3'b000;
        rdwr = 3'b111;
        for (int d = 0; d < 3; d++) begin
            addr[d]  = '0;
            wdata[d] = '0;
        end
        for (int i = 0; i < NRW; i++) m0[i] = 32'h0;

        repeat (3) tick();
        rst = 3'b000;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("reset ack %0d", d), 128'(ack[d]), 128'd0);
            check($sformatf("reset rd_data %0d", d), 128'(rdd[d]), 128'd0);
            check($sformatf("reset rw_regs %0d", d), rw[d], 128'd0);
        end
        tick();

        // Zero-delay instance: run the table with a shadow model of the RW words.
        for (int v = 0; v < 16; v++) begin
            if (!tbl[v].rd && tbl[v].a < 5'(NRW)) m0[tbl[v].a[1:0]] = tbl[v].wd;
            do_txn(0, tbl[v].rd, tbl[v].a, tbl[v].wd, tbl[v].exp_rd,
                   {m0[3], m0[2], m0[1], m0[0]}, 1, $sformatf("vec%0d", v));
        end

        // Delay 3: hold the request for 10 cycles. Expect exactly one ack, in cycle 4.
        rdwr[1] = 1'b1; addr[1] = 5'd0; req[1] = 1'b1;
        cnt = 0; at = 0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (ack[1]) begin cnt++; at = c; end
        end
        check("held req ack count", 128'(cnt), 128'd1);
        check("held req ack cycle", 128'(at), 128'd4);
        req[1] = 1'b0;
        tick(); tick();
        do_txn(1, 1'b1, 5'd6, 32'h0, 32'h1111_2222, 128'd0, 4, "re-raise");

        // Delay 3: the request drops while in WAIT, and the ack must still come.
        rdwr[1] = 1'b1; addr[1] = 5'd4; req[1] = 1'b1;
        tick();
        req[1] = 1'b0;
        k = 1; got = 0;
        while (!got && k < 20) begin
            tick(); k++;
            if (ack[1]) got = 1;
        end
        check("drop in wait ack", 128'(got), 128'd1);
        check("drop in wait latency", 128'(k), 128'd4);
        check("drop in wait rd_data", 128'(rdd[1]), 128'(32'h0bad_0000));
        tick(); tick();

        // Delay 3: reset mid-transaction aborts the write; a held request restarts.
        rdwr[1] = 1'b0; addr[1] = 5'd1; wdata[1] = 32'hfeed_face; req[1] = 1'b1;
        cnt = 0;
        tick(); if (ack[1]) cnt++;
        tick(); if (ack[1]) cnt++;
        rst[1] = 1'b1;
        tick(); if (ack[1]) cnt++;
        tick(); if (ack[1]) cnt++;
        rst[1] = 1'b0;
        check("reset abort no ack", 128'(cnt), 128'd0);
        check("reset abort word1", 128'(rw[1][63:32]), 128'd0);
        k = 0; got = 0;
        while (!got && k < 20) begin
            tick(); k++;
            if (ack[1]) got = 1;
        end
        check("post-reset ack", 128'(got), 128'd1);
        check("post-reset latency", 128'(k), 128'd4);
        check("post-reset word1", 128'(rw[1][63:32]), 128'(32'hfeed_face));
        req[1] = 1'b0;
        tick(); tick();

        // Delay 2: the bus changes after capture, and the captured fields must win.
        rdwr[2] = 1'b0; addr[2] = 5'd3; wdata[2] = 32'h1111_aaaa; req[2] = 1'b1;
        tick();
        addr[2] = 5'd0; wdata[2] = 32'h2222_bbbb;
        k = 1; got = 0;
        while (!got && k < 20) begin
            tick(); k++;
            if (ack[2]) got = 1;
        end
        check("capture ack", 128'(got), 128'd1);
        check("capture latency", 128'(k), 128'd3);
        check("capture rw_regs", rw[2], {32'h1111_aaaa, 32'h0, 32'h0, 32'h0});
        check("capture rd_data unchanged", 128'(rdd[2]), 128'd0);
        req[2] = 1'b0;
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
